// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with valid/ready handshakes; define ALU_MUL_EN for iterative MUL on op 111.
module alu_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);
   localparam int SH_W = $clog2(WIDTH);
   logic [SH_W-1:0]  sh;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] res;
   logic             c, v, fire, idle, is_mul;
   assign sh   = src2[SH_W-1:0];
   assign sum  = {1'b0, src1} + {1'b0, src2};
   assign diff = {1'b0, src1} - {1'b0, src2};
   always_comb begin
      case (op)
         3'b000: res = sum[WIDTH-1:0];
         3'b001: res = diff[WIDTH-1:0];
         3'b010: res = src1 & src2;
         3'b011: res = src1 | src2;
         3'b100: res = src1 ^ src2;
         3'b101: res = src1 << sh;
         3'b110: res = src1 >> sh;
`ifdef ALU_MUL_EN
         3'b111: res = '0;
`else
         3'b111: res = $signed(src1) >>> sh;
`endif
      endcase
   end
   assign c = op == 3'b000 ? sum[WIDTH] : op == 3'b001 ? diff[WIDTH] : 1'b0;
   assign v = op == 3'b000 ? (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]) :
              op == 3'b001 ? (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]) : 1'b0;
   assign in_ready = !reset && idle && (!out_valid || out_ready);
   assign fire     = in_valid && in_ready;
`ifdef ALU_MUL_EN
   typedef enum logic {IDLE, BUSY} state_t;
   state_t           state;
   logic [WIDTH-1:0] acc, ma, mb, acc_n;
   logic [SH_W-1:0]  cnt;
   assign acc_n  = acc + (mb[0] ? ma : '0);
   assign idle   = state == IDLE;
   assign is_mul = op == 3'b111;
`else
   assign idle   = 1'b1;
   assign is_mul = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
`ifdef ALU_MUL_EN
         state     <= IDLE;
         acc       <= '0;
         ma        <= '0;
         mb        <= '0;
         cnt       <= '0;
`endif
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (fire && !is_mul) begin
            result    <= res;
            flags     <= {res == '0, res[WIDTH-1], c, v};
            out_valid <= 1'b1;
         end
`ifdef ALU_MUL_EN
         if (fire && is_mul) begin
            state <= BUSY;
            acc   <= '0;
            ma    <= src1;
            mb    <= src2;
            cnt   <= SH_W'(WIDTH - 1);
         end
         if (state == BUSY) begin
            acc <= acc_n;
            ma  <= ma << 1;
            mb  <= mb >> 1;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
               state     <= IDLE;
               result    <= acc_n;
               flags     <= {acc_n == '0, acc_n[WIDTH-1], 2'b00};
               out_valid <= 1'b1;
            end
         end
`endif
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of alu_pipe at WIDTH=16 for whichever ALU_MUL_EN build is compiled.
module tb_alu_pipe;
   localparam int WIDTH = 16;
   logic             clk = 1'b0;
   logic             reset, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] src1, src2, result;
   logic [3:0]       flags;
   int               total = 0;
   int               fails = 0;
   alu_pipe #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags)
   );
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      in_valid = 1'b1;
      op       = o;
      src1     = a;
      src2     = b;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic chk_out(input string tag, input logic [WIDTH-1:0] r, input logic [3:0] f);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_result"}, 64'(result), 64'(r));
      chk({tag, "_flags"}, 64'(flags), 64'(f));
   endtask
   initial begin
      logic seen;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = '0;
      src1      = '0;
      src2      = '0;
      repeat (3) step;
      chk("reset_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b0;
      step;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_result", 64'(result), 64'd0);
      chk("reset_flags", 64'(flags), 64'd0);
      chk("reset_in_ready_after", 64'(in_ready), 64'd1);
      drive(3'b000, 16'hFFFF, 16'h0001);
      step;
      chk_out("add_wrap", 16'h0000, 4'b1010);
      drive(3'b001, 16'h8000, 16'h0001);
      step;
      chk_out("sub_ovf", 16'h7FFF, 4'b0001);
      drive(3'b001, 16'h0003, 16'h0005);
      step;
      chk_out("sub_borrow", 16'hFFFE, 4'b0110);
      drive(3'b010, 16'hF0F0, 16'h3C3C);
      step;
      chk_out("and", 16'h3030, 4'b0000);
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      drive(3'b011, 16'hF0F0, 16'h0F00);
      step;
      chk_out("or", 16'hFFF0, 4'b0100);
      drive(3'b100, 16'hAAAA, 16'hAAAA);
      step;
      chk_out("xor", 16'h0000, 4'b1000);
      drive(3'b110, 16'h8001, 16'h0010);
      step;
      chk_out("srl_amt0", 16'h8001, 4'b0100);
      drive(3'b110, 16'h8000, 16'h000F);
      step;
      chk_out("srl15", 16'h0001, 4'b0000);
      drive(3'b101, 16'h0001, 16'h0013);
      step;
      chk_out("sll_mask", 16'h0008, 4'b0000);
      out_ready = 1'b0;
      drive(3'b000, 16'h0002, 16'h0003);
      for (int i = 0; i < 5; i++) begin
         step;
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk_out("bp_hold", 16'h0008, 4'b0000);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      step;
      chk_out("bp_add", 16'h0005, 4'b0000);
      in_valid = 1'b0;
      step;
      chk("drain_valid", 64'(out_valid), 64'd0);
`ifdef ALU_MUL_EN
      drive(3'b111, 16'h0123, 16'h0010);
      step;
      in_valid = 1'b0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         chk("mul_busy_ready", 64'(in_ready), 64'd0);
         chk("mul_busy_valid", 64'(out_valid), 64'd0);
         step;
      end
      chk("mul_last_valid", 64'(out_valid), 64'd0);
      step;
      chk_out("mul", 16'h1230, 4'b0000);
      drive(3'b111, 16'h0003, 16'h0005);
      step;
      in_valid = 1'b0;
      repeat (5) step;
      reset = 1'b1;
      step;
      chk("mul_reset_ready", 64'(in_ready), 64'd0);
      reset = 1'b0;
      seen  = 1'b0;
      repeat (20) begin
         step;
         seen |= out_valid;
      end
      chk("mul_abort", 64'(seen), 64'd0);
      chk("mul_abort_idle", 64'(in_ready), 64'd1);
`else
      drive(3'b111, 16'h8000, 16'h0004);
      step;
      chk_out("sra", 16'hF800, 4'b0100);
      drive(3'b111, 16'h4000, 16'h0021);
      step;
      chk_out("sra_pos", 16'h2000, 4'b0000);
      in_valid = 1'b0;
`endif
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
